// File: rtl/phy_tx_recirc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// phy_tx_recirc_ctrl_pkg
//   Shared definitions for the phy_tx recirculator controller: FSM state
//   encodings, recirculator lane count, default timing parameters and the
//   saturating accumulator helper used by the optional statistics counter
//   (enabled with `define PHY_TX_RECIRC_STATS_EN).
// ----------------------------------------------------------------------------
package phy_tx_recirc_ctrl_pkg;

    // Encodings are visible on the state output, so they are fixed values.
    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    localparam int unsigned RECIRC_LANES    = 4;
    localparam int unsigned WORDS_W         = 16;

    localparam int unsigned INIT_CYCLES_DEF = 16;
    localparam int unsigned MAX_HOLD_DEF    = 32;
    localparam int unsigned CNT_W_DEF       = 6;

    // Adds a small lane count to the word total, pinning at all-ones
    // instead of wrapping.
    function automatic logic [WORDS_W-1:0] sat_add_words(
        input logic [WORDS_W-1:0] acc,
        input logic [2:0]         inc
    );
        logic [WORDS_W:0] sum;
        sum = {1'b0, acc} + {{(WORDS_W-2){1'b0}}, inc};
        return sum[WORDS_W] ? {WORDS_W{1'b1}} : sum[WORDS_W-1:0];
    endfunction

endpackage

// File: rtl/phy_tx_recirc_ctrl_popcount4.sv
// ----------------------------------------------------------------------------
// phy_tx_recirc_ctrl_popcount4
//   Combinational population count of the four recirculation valid bits.
//   Only compiled when PHY_TX_RECIRC_STATS_EN is defined, so the default
//   build carries no popcount logic at all.
// Ports
//   data_i   in  4  valid bits, one per recirculation lane
//   count_o  out 3  number of bits set in data_i (0..4)
// ----------------------------------------------------------------------------
`ifdef PHY_TX_RECIRC_STATS_EN
module phy_tx_recirc_ctrl_popcount4 (
    input  logic [3:0] data_i,
    output logic [2:0] count_o
);

    assign count_o = {2'b00, data_i[0]} + {2'b00, data_i[1]}
                   + {2'b00, data_i[2]} + {2'b00, data_i[3]};

endmodule
`endif

// File: rtl/phy_tx_recirc_ctrl.sv
// ----------------------------------------------------------------------------
// phy_tx_recirc_ctrl
//   Controller for the phy_tx recirculator. Drives the idle select
//   (0 = lanes 0-3 go downstream, 1 = lanes are diverted to recirculation
//   outputs 4-7), sequences link bring-up, holds traffic in recirculation
//   while downstream is not ready and flags a stall that lasts too long.
//
//   Optional feature: `define PHY_TX_RECIRC_STATS_EN adds a saturating total
//   of recirculated words. Without it recirc_words is constant zero.
//
// Ports
//   clk           in   1      clock, all logic on posedge
//   reset_L       in   1      asynchronous reset, active-low
//   init          in   1      start/restart request (level)
//   ready_down    in   1      downstream can accept lanes 0-3 this cycle
//   valid_in      in   4      lane 0-3 valids from upper logic (monitor only)
//   recirc_valid  in   4      recirculator valid_out_4..7
//   idle          out  1      recirculate select, registered
//   state         out  3      current FSM state
//   hold_cnt      out  CNT_W  consecutive cycles spent in HOLD
//   stall_err     out  1      sticky stall error
//   recirc_words  out  16     recirculated-word total (stats build only)
// ----------------------------------------------------------------------------
module phy_tx_recirc_ctrl
    import phy_tx_recirc_ctrl_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
    parameter int unsigned MAX_HOLD    = MAX_HOLD_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    init,
    input  logic                    ready_down,
    input  logic [RECIRC_LANES-1:0] valid_in,
    input  logic [RECIRC_LANES-1:0] recirc_valid,
    output logic                    idle,
    output logic [2:0]              state,
    output logic [CNT_W-1:0]        hold_cnt,
    output logic                    stall_err,
    output logic [WORDS_W-1:0]      recirc_words
);

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             stall_err_q, stall_err_d;
    logic             idle_q, idle_d;
    logic             init_prev_q;
    logic             init_rise;

    // ERROR only restarts on a fresh request, not on init held high.
    assign init_rise = init & ~init_prev_q;

    // ------------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        stall_err_d = stall_err_q;

        case (state_q)
            ST_RESET: begin
                if (init) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end
            end

            ST_INIT: begin
                if (!init) begin
                    state_d    = ST_RESET;
                    init_cnt_d = '0;
                end else if (init_cnt_q == INIT_LAST) begin
                    init_cnt_d = '0;
                    if (ready_down) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = CNT_ONE;
                    end
                end else begin
                    init_cnt_d = init_cnt_q + CNT_ONE;
                end
            end

            ST_ACTIVE: begin
                if (!init) begin
                    state_d = ST_RESET;
                end else if (!ready_down) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = CNT_ONE;
                end
            end

            ST_HOLD: begin
                // init=0 beats everything; a returning ready_down beats the
                // error, so a stall that ends exactly at the limit is clean.
                if (!init) begin
                    state_d    = ST_RESET;
                    hold_cnt_d = '0;
                end else if (ready_down) begin
                    state_d    = ST_ACTIVE;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    state_d     = ST_ERROR;
                    stall_err_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end

            ST_ERROR: begin
                // hold_cnt keeps showing the saturated stall length here.
                if (init_rise) begin
                    state_d     = ST_INIT;
                    init_cnt_d  = '0;
                    hold_cnt_d  = '0;
                    stall_err_d = 1'b0;
                end
            end

            default: begin
                state_d     = ST_RESET;
                init_cnt_d  = '0;
                hold_cnt_d  = '0;
                stall_err_d = 1'b0;
            end
        endcase

        // Decoded from the next state so idle moves on the same edge as state.
        idle_d = (state_d != ST_ACTIVE);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= ST_RESET;
            init_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            stall_err_q <= 1'b0;
            idle_q      <= 1'b1;
            init_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            stall_err_q <= stall_err_d;
            idle_q      <= idle_d;
            init_prev_q <= init;
        end
    end

    assign idle      = idle_q;
    assign state     = state_q;
    assign hold_cnt  = hold_cnt_q;
    assign stall_err = stall_err_q;

    // ------------------------------------------------------------------------
    // Recirculated-word statistics
    // ------------------------------------------------------------------------
`ifdef PHY_TX_RECIRC_STATS_EN
    logic [2:0]         lanes_now;
    logic [WORDS_W-1:0] words_q, words_d;
    logic               words_clr;
    logic               unused_inputs;

    phy_tx_recirc_ctrl_popcount4 u_popcount4 (
        .data_i  (recirc_valid),
        .count_o (lanes_now)
    );

    // A new bring-up starts a fresh total.
    assign words_clr = (state_q == ST_RESET) && init;
    assign words_d   = words_clr ? '0 : sat_add_words(words_q, lanes_now);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    assign recirc_words  = words_q;
    assign unused_inputs = ^valid_in;
`else
    logic unused_inputs;

    assign recirc_words  = '0;
    assign unused_inputs = ^{valid_in, recirc_valid};
`endif

endmodule
